// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
//
// Shares one combinational 32-bit ALU between NUM_REQ requesters. Requests are
// arbitrated round-robin. The winner's operands are held on the ALU for as many
// cycles as its opcode class needs, and the result is then captured. It is
// returned to the requester over a valid/ready response channel.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   MUL_CYCLES  operand hold cycles for the multiply class (>= 1)
//   DIV_CYCLES  operand hold cycles for the divide class (>= 1)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester request valid / one-hot accept pulse
//   req_a, req_b         packed 32-bit operands, requester i at [32i+31:32i]
//   req_sel              packed 4-bit opcodes, requester i at [4i+3:4i]
//   alu_a, alu_b, alu_sel  operand/select drive to the ALU
//   alu_out, alu_zero    result and Zero flag from the ALU
//   resp_valid/ready     response handshake
//   resp_id              index of the granted requester
//   resp_data, resp_zero captured result and Zero flag
//   resp_err             divide-by-zero trap flag (0 unless the trap is built)
//   busy                 high whenever the FSM is not idle
//
// Build option:
//   ALU_SCHED_DIV0_TRAP_EN  when defined, an integer divide (0011/0111) with
//                           B == 0 is not issued. It is answered immediately
//                           with data 0, zero 1 and err 1.
// -----------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*32-1:0]      req_a,
    input  logic [NUM_REQ*32-1:0]      req_b,
    input  logic [NUM_REQ*4-1:0]       req_sel,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [31:0]                alu_a,
    output logic [31:0]                alu_b,
    output logic [3:0]                 alu_sel,
    input  logic [31:0]                alu_out,
    input  logic                       alu_zero,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [31:0]                resp_data,
    output logic                       resp_zero,
    output logic                       resp_err,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int MAX_C = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       op_a, op_b;
    logic [3:0]        op_sel;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [31:0]       sel_a, sel_b;
    logic [3:0]        sel_op;
    logic              accept;
    logic              trap_hit;

    // The hold count minus one, so that a count of zero means "capture now".
    function automatic logic [CNT_W-1:0] class_cnt(input logic [3:0] op);
        case (op)
            4'b0010, 4'b0110, 4'b1110: return CNT_W'(MUL_CYCLES - 1);
            4'b0011, 4'b0111, 4'b1111: return CNT_W'(DIV_CYCLES - 1);
            default:                   return '0;
        endcase
    endfunction

    // Round-robin search. The first pass covers indices at or above ptr. The
    // second pass wraps around to the indices below ptr.
    // NOTE: every variable written here gets a default first; otherwise a
    // path that skips the assignment would infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) >= ptr)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) < ptr)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_sel[4*i +: 4];
            end
        end
    end

`ifdef ALU_SCHED_DIV0_TRAP_EN
    assign trap_hit = ((sel_op == 4'b0011) || (sel_op == 4'b0111)) && (sel_b == 32'd0);
`else
    assign trap_hit = 1'b0;
`endif

    // Next state and the accept pulse. req_ready is forced low during reset
    // so that every output reads zero while rst is held.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found && !rst) begin
                    accept               = 1'b1;
                    req_ready[grant_idx] = 1'b1;
                    state_next           = trap_hit ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == '0) state_next = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and response registers are reset explicitly
            // because their values are visible on outputs right after reset.
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_zero <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        resp_id <= grant_idx;
                        ptr     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        cnt     <= class_cnt(sel_op);
                        if (trap_hit) begin
                            // Trapped divides never reach the ALU.
                            resp_data <= '0;
                            resp_zero <= 1'b1;
                        end else begin
                            op_a   <= sel_a;
                            op_b   <= sel_b;
                            op_sel <= sel_op;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        resp_data <= alu_out;
                        resp_zero <= alu_zero;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SCHED_DIV0_TRAP_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && accept) begin
            err_q <= trap_hit;
        end else if (state == S_BUSY && cnt == '0) begin
            err_q <= 1'b0;
        end
    end
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // The operand registers only change on accept, so the ALU inputs stay
    // constant for the whole BUSY window.
    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_sel    = op_sel;
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for alu_rr_scheduler (default parameters: NUM_REQ=4, MUL_CYCLES=3,
// DIV_CYCLES=8). A small behavioural ALU model is attached to the ALU ports.
// Inputs are driven on the falling edge and outputs are sampled there (or #1
// later), away from the rising edge. Expected trap behaviour follows the
// ALU_SCHED_DIV0_TRAP_EN build option.
// -----------------------------------------------------------------------------
module tb_alu_rr_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_a, req_b;
    logic [N*4-1:0]  req_sel;
    logic [N-1:0]    req_ready;
    logic [31:0]     alu_a, alu_b, alu_out;
    logic [3:0]      alu_sel;
    logic            alu_zero;
    logic            resp_valid, resp_ready;
    logic [1:0]      resp_id;
    logic [31:0]     resp_data;
    logic            resp_zero, resp_err, busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_rr_scheduler #(.NUM_REQ(N), .MUL_CYCLES(3), .DIV_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: add, sub, mul, unsigned div, xor for everything else.
    always_comb begin
        case (alu_sel)
            4'b0000:                   alu_out = alu_a + alu_b;
            4'b0001:                   alu_out = alu_a - alu_b;
            4'b0010, 4'b0110, 4'b1110: alu_out = alu_a * alu_b;
            4'b0011, 4'b0111, 4'b1111: alu_out = (alu_b == 0) ? 32'hFFFF_FFFF : alu_a / alu_b;
            default:                   alu_out = alu_a ^ alu_b;
        endcase
    end
    assign alu_zero = (alu_out == 32'd0);

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sel[4*i +: 4] = op;
        req_valid[i]      = 1'b1;
    endtask

    // Called in the accept cycle: drops all requests on the next falling edge
    // and counts cycles until resp_valid, or -1 once the budget expires.
    task automatic accept_then_wait(input int max, output int cycles);
        int c;
        @(negedge clk);
        c = 1;
        req_valid = '0;
        while (!resp_valid && c < max) begin
            @(negedge clk);
            c++;
        end
        cycles = resp_valid ? c : -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; resp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_id, resp_data,
             resp_zero, resp_err, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b a=%h b=%h sel=%h rv=%b id=%0d d=%h z=%b e=%b busy=%b, want all 0",
                     req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_id, resp_data,
                     resp_zero, resp_err, busy);
        end
        req_valid = '1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        int c;
        for (int i = 0; i < N; i++) set_req(i, 32'd5, 32'd5, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                n_err++;
                $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!resp_valid && c < 12);
            n_cmp++;
            if (c !== 2 || resp_data !== 32'd0 || resp_zero !== 1'b1 || resp_id !== 2'(k % 4)) begin
                n_err++;
                $display("FAIL rr_resp%0d: lat=%0d data=%0d zero=%b id=%0d want lat=2 data=0 zero=1 id=%0d",
                         k, c, resp_data, resp_zero, resp_id, k % 4);
            end
            if (k == 4) req_valid = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_single_add;
        int c;
        set_req(0, 32'd10, 32'd20, 4'b0000);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL add_ready: got %b want 0001", req_ready);
        end
        accept_then_wait(12, c);
        n_cmp++;
        if (c !== 2) begin
            n_err++;
            $display("FAIL add_latency: got %0d want 2", c);
        end
        n_cmp++;
        if (resp_data !== 32'd30 || resp_zero !== 1'b0 || resp_id !== 2'd0 || resp_err !== 1'b0) begin
            n_err++;
            $display("FAIL add_resp: data=%0d zero=%b id=%0d err=%b want 30 0 0 0",
                     resp_data, resp_zero, resp_id, resp_err);
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL add_idle: rv=%b busy=%b want 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_divide;
        set_req(2, 32'd100, 32'd4, 4'b0011);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL div_ready: got %b want 0100", req_ready);
        end
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            req_valid = '0;
            n_cmp++;
            if (resp_valid !== 1'b0 || busy !== 1'b1 || alu_a !== 32'd100 ||
                alu_b !== 32'd4 || alu_sel !== 4'b0011) begin
                n_err++;
                $display("FAIL div_hold_t%0d: rv=%b busy=%b a=%0d b=%0d sel=%b want 0 1 100 4 0011",
                         t, resp_valid, busy, alu_a, alu_b, alu_sel);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd25 || resp_id !== 2'd2 || resp_zero !== 1'b0) begin
            n_err++;
            $display("FAIL div_resp: rv=%b data=%0d id=%0d zero=%b want 1 25 2 0",
                     resp_valid, resp_data, resp_id, resp_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int c;
        resp_ready = 1'b0;
        set_req(3, 32'd7, 32'd3, 4'b0010);
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL bp_ready: got %b want 1000", req_ready);
        end
        accept_then_wait(12, c);
        n_cmp++;
        if (c !== 4) begin
            n_err++;
            $display("FAIL bp_latency: got %0d want 4", c);
        end
        set_req(0, 32'd1, 32'd1, 4'b0000);
        for (int t = 0; t < 5; t++) begin
            #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_data !== 32'd21 || resp_id !== 2'd3 || req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_hold_t%0d: rv=%b data=%0d id=%0d ready=%b want 1 21 3 0000",
                         t, resp_valid, resp_data, resp_id, req_ready);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_ready_in_resp: got %b want 0000", req_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_next_grant: got %b want 0001", req_ready);
        end
        accept_then_wait(12, c);
        n_cmp++;
        if (c !== 2 || resp_data !== 32'd2 || resp_id !== 2'd0) begin
            n_err++;
            $display("FAIL bp_next_resp: lat=%0d data=%0d id=%0d want 2 2 0", c, resp_data, resp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_div0;
        int c;
        set_req(1, 32'd1, 32'd0, 4'b0111);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL div0_ready: got %b want 0010", req_ready);
        end
        accept_then_wait(15, c);
`ifdef ALU_SCHED_DIV0_TRAP_EN
        n_cmp++;
        if (c !== 1 || resp_data !== 32'd0 || resp_zero !== 1'b1 || resp_err !== 1'b1 || resp_id !== 2'd1) begin
            n_err++;
            $display("FAIL div0_trap: lat=%0d data=%0d zero=%b err=%b id=%0d want 1 0 1 1 1",
                     c, resp_data, resp_zero, resp_err, resp_id);
        end
`else
        n_cmp++;
        if (c !== 9 || resp_err !== 1'b0 || resp_id !== 2'd1) begin
            n_err++;
            $display("FAIL div0_issue: lat=%0d err=%b id=%0d want 9 0 1", c, resp_err, resp_id);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy;
        int c;
        set_req(2, 32'd100, 32'd4, 4'b0011);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL rmb_ready: got %b want 0100", req_ready);
        end
        repeat (3) @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        req_valid = '1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            n_cmp++;
            if ({req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_id, resp_data,
                 resp_zero, resp_err, busy} !== '0) begin
                n_err++;
                $display("FAIL rmb_outputs_t%0d: ready=%b a=%h b=%h sel=%h rv=%b id=%0d d=%h busy=%b, want all 0",
                         t, req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_id, resp_data, busy);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'd3, 32'd4, 4'b0000);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL rmb_first_grant: got %b want 0001", req_ready);
        end
        accept_then_wait(12, c);
        n_cmp++;
        if (c !== 2 || resp_data !== 32'd7 || resp_id !== 2'd0) begin
            n_err++;
            $display("FAIL rmb_resp: lat=%0d data=%0d id=%0d want 2 7 0", c, resp_data, resp_id);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single_add;
        test_divide;
        test_backpressure;
        test_div0;
        test_reset_mid_busy;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
